uart_rx_buffered: RTL
=====================

# uart_rx_buffered

Serial receive half of the RS-232 path: recovers 8N1 frames from the `rs232_rx` pin and queues received bytes in a first-word-fall-through FIFO. It presents the same consumer handshake the PicoBlaze port logic already drives: `rx_data_out`, `rx_data_present` and a one-cycle `read_rx_data_ack` pop. It sits between the `rs232_rx` pad and the CPU input-port mux. It is the receiver counterpart of the UART transmit path.

## Interface
- `CLK_HZ`, 100000000, system clock frequency in Hz.
- `BAUD`, 115200, line rate in bits per second.
- `FIFO_DEPTH`, 16, receive buffer entries; must be a power of two, at least 2.
- Derived: `DIV = CLK_HZ / (16*BAUD)`, truncated (54 at defaults). Must be at least 2.

- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `rs232_rx`  in  1  asynchronous serial line; idles at 1.
- `rx_data_out`  out  8  FIFO head byte; 8'h00 when the FIFO is empty.
- `rx_data_present`  out  1  FIFO non-empty.
- `read_rx_data_ack`  in  1  pop request; one entry is popped per cycle it is high while present.
- `rx_buffer_full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `rx_overrun`  out  1  one-cycle pulse when a received byte is dropped because the FIFO is full.
- `framing_error`  out  1  one-cycle pulse on a bad stop bit; see Configuration.

## Operation
- **Input synchronizer.** `rs232_rx` passes through a 2-flop synchronizer; both flops reset to 1. All decoding uses the synchronized value `rxs`.
- **Tick generator.** A prescaler counts 0..DIV-1 and asserts `tick` for one cycle when count == DIV-1. The prescaler is forced to 0 on the IDLE→START transition.
- **Sample counter.** A 4-bit counter counts ticks within a bit.
- **FSM.** States are IDLE, START, DATA, STOP; the reset state is IDLE.
  - **IDLE:** when `rxs` == 0, go to START and clear the sample counter and prescaler.
  - **START:** on the 8th tick (mid start bit), sample `rxs`. If 1, it is a false start and the FSM returns to IDLE with no output. If 0, go to DATA with the sample counter and bit index cleared.
  - **DATA:** every 16th tick, shift `rxs` into the shift register, LSB first. After bit index 7, go to STOP.
  - **STOP:** on the 16th tick (mid stop bit), sample `rxs`, perform the enqueue decision, then return to IDLE.
- **Enqueue decision.**
  - If the FIFO is not full, or a pop occurs in the same cycle, the byte is written.
  - Otherwise the byte is dropped and `rx_overrun` pulses.
- **FIFO.**
  - Read and write pointers are log2(FIFO_DEPTH) bits; the count is log2(FIFO_DEPTH)+1 bits.
  - Pointers wrap modulo FIFO_DEPTH.
  - A pop while empty is ignored.
  - A simultaneous push and pop leaves the count unchanged, and the popped entry is the old head.
- **Reset.** A reset at any time, including mid-frame, returns the FSM to IDLE and empties the FIFO. Any partial byte is discarded.
- **Reset values:**
  - `rx_data_out` = 8'h00.
  - `rx_data_present`, `rx_buffer_full`, `rx_overrun` and `framing_error` = 0.
  - Synchronizer flops = 1.

## Timing
- The start edge is detected 2 cycles after the pin falls (synchronizer delay).
- Data bit k is sampled at tick 8+16(k+1) after the start edge is detected. The stop bit is sampled at tick 152.
- The FIFO write, `rx_overrun` and `framing_error` take effect on the clock edge of the stop-sample tick. `rx_data_present` and `rx_data_out` reflect the new entry on the following cycle.
- **Pop timing:**
  - A pop seen on edge N updates `rx_data_out` to the next entry (or 8'h00 if now empty) after edge N.
  - `rx_data_present` and `rx_buffer_full` update on the same edge.
- Status outputs are registered; `rx_data_out` is combinational from the head entry, gated by the empty flag.
- Tolerates ±3% baud mismatch. Back-to-back frames with a one-bit stop are received without loss.

## Configuration
- `UART_RX_FRAMING_ERR_EN`
  - **Defined:** a stop-bit sample of 0 discards the byte (no FIFO write, no overrun), pulses `framing_error` for one cycle, and the FSM returns to IDLE.
  - **Undefined:** the stop bit is not checked. Every completed frame goes through the enqueue decision, and `framing_error` is tied to 0.

## Test plan
Bench parameters: `CLK_HZ` = 64*`BAUD`, giving `DIV` = 4.
- **Single byte.** Frame 0x55 → one cycle after the stop sample, `rx_data_present`=1 and `rx_data_out`=0x55. A one-cycle ack → the next cycle shows `rx_data_present`=0 and `rx_data_out`=0x00.
- **Glitch rejection.** `rs232_rx` low for 12 cycles (3 ticks), then high → no write, FSM in IDLE. A following frame 0xC3 is received correctly.
- **Overflow (`FIFO_DEPTH`=16).** Frames 0x00..0x10 with no acks:
  - `rx_buffer_full`=1 after frame 0x0F.
  - `rx_overrun` pulses exactly once, on frame 0x10.
  - 16 acks return 0x00..0x0F in order, then `rx_data_present`=0.
- **Full-FIFO pop race.** FIFO full, with an ack asserted on the stop-sample cycle of the next frame (0x7E) → byte accepted, count stays 16, no `rx_overrun`, and 0x7E is the last entry read.
- **Bad stop bit.** Frame 0xA5 with stop bit 0:
  - With `UART_RX_FRAMING_ERR_EN`: `framing_error` pulses once and the FIFO stays empty.
  - Without it: 0xA5 is queued and `framing_error` stays 0.
- **Reset mid-frame.** Assert `reset` for 1 cycle during data bit 4, with 2 entries queued → the next cycle shows all outputs at reset values. A subsequent frame 0x3C is received as the sole entry.

Source files
------------

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with 16x oversampling feeding a first-word-fall-through FIFO.
// Optional stop-bit checking is enabled by defining UART_RX_FRAMING_ERR_EN.
module uart_rx_buffered #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rs232_rx,
    output logic [7:0] rx_data_out,
    output logic       rx_data_present,
    input  logic       read_rx_data_ack,
    output logic       rx_buffer_full,
    output logic       rx_overrun,
    output logic       framing_error
);
    localparam int DIV = CLK_HZ / (16 * BAUD);
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t         state_r, state_nxt_s;
    logic           rx_meta_r, rxs_r;
    logic [PW-1:0]  presc_r;
    logic           tick_s;
    logic [3:0]     sample_cnt_r;
    logic [2:0]     bit_idx_r;
    logic [7:0]     shift_r;
    logic           start_s, cnt_clr_s, cnt_inc_s, bit_shift_s, frame_done_s;
    logic           push_s, pop_s, overrun_s;
    logic [7:0]     mem_r [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_r, rd_ptr_r;
    logic [AW:0]    count_r, count_nxt_s;
    logic           present_r, full_r, overrun_r;

    // Two-flop synchronizer for the asynchronous line, idling high
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rxs_r     <= 1'b1;
        end else begin
            rx_meta_r <= rs232_rx;
            rxs_r     <= rx_meta_r;
        end
    end

    assign tick_s = (presc_r == DIV_LAST);

    // Oversampling prescaler, realigned to the detected start edge
    always_ff @(posedge clk) begin
        if (reset || start_s || tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and per-tick control strobes
    always_comb begin
        state_nxt_s  = state_r;
        start_s      = 1'b0;
        cnt_clr_s    = 1'b0;
        cnt_inc_s    = 1'b0;
        bit_shift_s  = 1'b0;
        frame_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!rxs_r) begin
                    state_nxt_s = ST_START;
                    start_s     = 1'b1;
                    cnt_clr_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s && (sample_cnt_r == 4'd7)) begin
                    cnt_clr_s   = 1'b1;
                    state_nxt_s = rxs_r ? ST_IDLE : ST_DATA;
                end else if (tick_s) begin
                    cnt_inc_s = 1'b1;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    cnt_inc_s = 1'b1;
                    if (sample_cnt_r == 4'd15) begin
                        bit_shift_s = 1'b1;
                        state_nxt_s = (bit_idx_r == 3'd7) ? ST_STOP : ST_DATA;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (tick_s && (sample_cnt_r == 4'd15)) begin
                    frame_done_s = 1'b1;
                    state_nxt_s  = ST_IDLE;
                end else if (tick_s) begin
                    cnt_inc_s = 1'b1;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sample counter, bit index and LSB-first shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_cnt_r <= 4'd0;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'h00;
        end else begin
            if (cnt_clr_s) begin
                sample_cnt_r <= 4'd0;
                bit_idx_r    <= 3'd0;
            end else if (cnt_inc_s) begin
                sample_cnt_r <= sample_cnt_r + 4'd1;
            end
            if (bit_shift_s) begin
                shift_r   <= {rxs_r, shift_r[7:1]};
                bit_idx_r <= bit_idx_r + 3'd1;
            end
        end
    end

    // A full FIFO still accepts the byte when a pop frees a slot on the same edge
    always_comb begin
        pop_s     = read_rx_data_ack && present_r;
        push_s    = 1'b0;
        overrun_s = 1'b0;
        if (frame_done_s) begin
`ifdef UART_RX_FRAMING_ERR_EN
            if (!rxs_r) begin
                push_s = 1'b0;
            end else if (!full_r || pop_s) begin
                push_s = 1'b1;
            end else begin
                overrun_s = 1'b1;
            end
`else
            if (!full_r || pop_s) begin
                push_s = 1'b1;
            end else begin
                overrun_s = 1'b1;
            end
`endif
        end else begin
            push_s = 1'b0;
        end
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + (AW + 1)'(1);
            2'b01:   count_nxt_s = count_r - (AW + 1)'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO pointers, occupancy and registered status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            present_r <= 1'b0;
            full_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r   <= count_nxt_s;
            present_r <= (count_nxt_s != '0);
            full_r    <= (count_nxt_s == FULL_CNT);
            overrun_r <= overrun_s;
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= shift_r;
        end
    end

`ifdef UART_RX_FRAMING_ERR_EN
    logic ferr_s, ferr_r;
    assign ferr_s = frame_done_s && !rxs_r;

    // Framing-error pulse register
    always_ff @(posedge clk) begin
        if (reset) begin
            ferr_r <= 1'b0;
        end else begin
            ferr_r <= ferr_s;
        end
    end
    assign framing_error = ferr_r;
`else
    assign framing_error = 1'b0;
`endif

    assign rx_data_out     = present_r ? mem_r[rd_ptr_r] : 8'h00;
    assign rx_data_present = present_r;
    assign rx_buffer_full  = full_r;
    assign rx_overrun      = overrun_r;
endmodule
